// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams a length-prefixed little-endian program image into instruction memory,
// holding the CPU in reset until the whole image has been written.
module imem_boot_loader #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic        reload,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        busy,
  output logic        err
);
  localparam logic [2:0] S_LEN   = 3'd0;
  localparam logic [2:0] S_DATA  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;
  localparam int WW = DEPTH_LOG2 + 1;
  localparam logic [32:0] MAX_WORDS = 33'd1 << DEPTH_LOG2;
  logic [2:0]    state_q, state_d;
  logic [1:0]    byte_q, byte_d;
  logic [WW-1:0] word_q, word_d, word_inc;
  logic [31:0]   len_q, len_d, asm_q, asm_d, waddr_q, waddr_d, wdata_q, wdata_d;
  logic [31:0]   len_shift, asm_shift;
  logic          we_q, we_d, err_q, err_d, take;
  assign rx_ready   = state_q == S_LEN || state_q == S_DATA;
  assign cpu_reset  = state_q != S_RUN;
  assign busy       = state_q == S_LEN || state_q == S_DATA || state_q == S_DRAIN;
  assign err        = err_q;
  assign imem_we    = we_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;
  // Bytes shift in from the top so the first byte of each group ends up in [7:0].
  always_comb begin
    take      = rx_valid & rx_ready;
    len_shift = {rx_data, len_q[31:8]};
    asm_shift = {rx_data, asm_q[31:8]};
    word_inc  = word_q + 1'b1;
    state_d   = state_q;
    byte_d    = byte_q;
    word_d    = word_q;
    len_d     = len_q;
    asm_d     = asm_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    case (state_q)
      S_LEN: if (take) begin
        len_d  = len_shift;
        byte_d = byte_q + 2'd1;
        if (byte_q == 2'd3)
          state_d = len_shift == 32'd0 ? S_DRAIN :
                    {1'b0, len_shift} > MAX_WORDS ? S_ERR : S_DATA;
      end
      S_DATA: if (take) begin
        asm_d  = asm_shift;
        byte_d = byte_q + 2'd1;
        if (byte_q == 2'd3) begin
          we_d    = 1'b1;
          wdata_d = asm_shift;
          waddr_d = 32'({word_q, 2'b00});
          word_d  = word_inc;
          if (32'(word_inc) == len_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: state_d = S_RUN;
      S_RUN: if (reload) begin
        state_d = S_LEN;
        byte_d  = 2'd0;
        word_d  = '0;
      end
      default: state_d = S_ERR;
    endcase
    err_d = err_q | (state_d == S_ERR);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_LEN;
      byte_q  <= 2'd0;
      word_q  <= '0;
      len_q   <= 32'd0;
      asm_q   <= 32'd0;
      waddr_q <= 32'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
      len_q   <= len_d;
      asm_q   <= asm_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed checks of image loading, release timing, reload, oversize and reset.
module tb_imem_boot_loader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic reload = 1'b0;
  logic rx_ready, imem_we, cpu_reset, busy, err;
  logic [31:0] imem_waddr, imem_wdata;
  int checks = 0;
  int failures = 0;
  logic [31:0] wa_q[$];
  logic [31:0] wd_q[$];

  imem_boot_loader #(.DEPTH_LOG2(2)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .reload(reload), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (imem_we === 1'b1) begin
    wa_q.push_back(imem_waddr);
    wd_q.push_back(imem_wdata);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) begin
      rx_valid = 1'b0;
      rx_data = 8'($urandom);
      tick();
    end
    rx_valid = 1'b1;
    rx_data = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++) send(w[8*i +: 8], gap);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  task automatic check_write(input string tag, input int i, input logic [31:0] a, input logic [31:0] d);
    check({tag, "_addr"}, wa_q[i], a);
    check({tag, "_data"}, wd_q[i], d);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_we"}, 32'(imem_we), 32'd0);
    check({tag, "_waddr"}, imem_waddr, 32'd0);
    check({tag, "_wdata"}, imem_wdata, 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    tick();
    tick();
    check_reset_vals("rst");
    reset = 1'b0;
    tick();
    // Normal back-to-back load of two words
    send_word(32'd2, 0);
    send_word(32'h00500513, 0);
    send_word(32'h0000006F, 0);
    check("norm_drain_cpu_reset", 32'(cpu_reset), 32'd1);
    check("norm_drain_rx_ready", 32'(rx_ready), 32'd0);
    check("norm_drain_we", 32'(imem_we), 32'd1);
    tick();
    check("norm_run_cpu_reset", 32'(cpu_reset), 32'd0);
    check("norm_run_busy", 32'(busy), 32'd0);
    check("norm_run_rx_ready", 32'(rx_ready), 32'd0);
    check("norm_nwrites", wa_q.size(), 32'd2);
    check_write("norm_w0", 0, 32'h0, 32'h00500513);
    check_write("norm_w1", 1, 32'h4, 32'h0000006F);
    // reload returns to LEN, address/data hold
    wa_q.delete(); wd_q.delete();
    pulse_reload();
    check("reload_cpu_reset", 32'(cpu_reset), 32'd1);
    check("reload_rx_ready", 32'(rx_ready), 32'd1);
    check("reload_waddr_hold", imem_waddr, 32'h4);
    check("reload_wdata_hold", imem_wdata, 32'h6F);
    // Throttled: 3 idle cycles before every byte
    send_word(32'd2, 3);
    send_word(32'h00500513, 3);
    send_word(32'h0000006F, 3);
    check("thr_drain_cpu_reset", 32'(cpu_reset), 32'd1);
    tick();
    check("thr_run_cpu_reset", 32'(cpu_reset), 32'd0);
    tick();
    check("thr_nwrites", wa_q.size(), 32'd2);
    check_write("thr_w0", 0, 32'h0, 32'h00500513);
    check_write("thr_w1", 1, 32'h4, 32'h0000006F);
    // Single-word image after reload
    wa_q.delete(); wd_q.delete();
    pulse_reload();
    send_word(32'd1, 0);
    send_word(32'hDEADBEEF, 1);
    tick();
    check("one_cpu_reset", 32'(cpu_reset), 32'd0);
    check("one_nwrites", wa_q.size(), 32'd1);
    check_write("one_w0", 0, 32'h0, 32'hDEADBEEF);
    // Zero length image
    wa_q.delete(); wd_q.delete();
    pulse_reload();
    send_word(32'd0, 0);
    check("zero_drain_busy", 32'(busy), 32'd1);
    check("zero_drain_cpu_reset", 32'(cpu_reset), 32'd1);
    check("zero_drain_rx_ready", 32'(rx_ready), 32'd0);
    tick();
    check("zero_run_cpu_reset", 32'(cpu_reset), 32'd0);
    check("zero_nwrites", wa_q.size(), 32'd0);
    // Maximum image: 4 words with DEPTH_LOG2=2
    pulse_reload();
    send_word(32'd4, 0);
    for (int i = 0; i < 4; i++) send_word(32'h11110000 + 32'(i), 0);
    tick();
    check("max_cpu_reset", 32'(cpu_reset), 32'd0);
    check("max_err", 32'(err), 32'd0);
    check("max_nwrites", wa_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) check_write("max_w", i, 32'(4 * i), 32'h11110000 + 32'(i));
    // Reset in the middle of a word
    wa_q.delete(); wd_q.delete();
    pulse_reload();
    send_word(32'd2, 0);
    send(8'hAA, 0);
    send(8'hBB, 0);
    reset = 1'b1;
    #1;
    check_reset_vals("midrst");
    tick();
    reset = 1'b0;
    tick();
    tick();
    check("midrst_nwrites", wa_q.size(), 32'd0);
    check("midrst_rx_ready", 32'(rx_ready), 32'd1);
    // Oversize: N=5 exceeds 4 words
    send_word(32'd5, 0);
    check("ovr_err", 32'(err), 32'd1);
    check("ovr_rx_ready", 32'(rx_ready), 32'd0);
    check("ovr_cpu_reset", 32'(cpu_reset), 32'd1);
    check("ovr_busy", 32'(busy), 32'd0);
    send_word(32'h01020304, 0);
    pulse_reload();
    tick();
    check("ovr_reload_err", 32'(err), 32'd1);
    check("ovr_reload_cpu_reset", 32'(cpu_reset), 32'd1);
    check("ovr_reload_rx_ready", 32'(rx_ready), 32'd0);
    check("ovr_nwrites", wa_q.size(), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("ovr_clr_err", 32'(err), 32'd0);
    check("ovr_clr_rx_ready", 32'(rx_ready), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
